// File: rtl/stream_byte_swapper_pkg.sv
// Shared constants and the group byte-reversal helper for the stream byte swapper.
// Byte 0 of a beat sits at the MSB end of the bus (Avalon symbol order).
package stream_byte_swapper_pkg;

    localparam logic [1:0] CSR_CTRL  = 2'd0;
    localparam logic [1:0] CSR_PKTS  = 2'd1;
    localparam logic [1:0] CSR_BYTES = 2'd2;
    localparam logic [1:0] CSR_ERRS  = 2'd3;

    localparam int MODE_W    = 3;
    localparam int MAX_BYTES = 64;
    localparam int MAX_BITS  = MAX_BYTES * 8;

    // Groups are power-of-two sized and aligned, so the source byte of any lane
    // is its own index with the in-group offset bits inverted (k ^ (g-1)).
    // The same identity holds from either end of the bus, so LSB indexing is safe.
    function automatic logic [MAX_BITS-1:0] byteswap_group(
        input logic [MAX_BITS-1:0] data,
        input int                  lg_bytes,
        input logic [MODE_W-1:0]   m
    );
        logic [MAX_BITS-1:0] res;
        int eff;
        int mask;
        eff  = (int'(m) > lg_bytes) ? lg_bytes : int'(m);
        mask = (32'sd1 <<< eff) - 32'sd1;
        res  = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            res[k*8 +: 8] = data[(k ^ mask)*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_byte_swapper_if.sv
// Avalon-ST beat bundle used on both sides of the byte swapper.
// master drives the beat, slave returns ready (readyLatency 0).
interface stream_byte_swapper_if
    import stream_byte_swapper_pkg::*;
#(
    parameter int DATA_BYTES = 8
);
    localparam int EMPTY_W = $clog2(DATA_BYTES);

    logic [DATA_BYTES*8-1:0] data;
    logic [EMPTY_W-1:0]      empty;
    logic                    valid;
    logic                    ready;
    logic                    startofpacket;
    logic                    endofpacket;

    modport master (
        output data, empty, valid, startofpacket, endofpacket,
        input  ready
    );

    modport slave (
        input  data, empty, valid, startofpacket, endofpacket,
        output ready
    );

endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry registered skid buffer: head register drives the output, the skid
// register absorbs the one beat that lands while the consumer stalls.
module stream_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] skid_r;
    logic [1:0]       count_r;
    logic [1:0]       count_s;
    logic             valid_r;
    logic             ready_r;
    logic             push_s;
    logic             pop_s;

    assign push_s    = in_valid & ready_r;
    assign pop_s     = valid_r & out_ready;
    assign in_ready  = ready_r;
    assign out_valid = valid_r;
    assign out_data  = head_r;

    // Next occupancy from this cycle's push/pop pair
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + 2'd1;
            2'b01:   count_s = count_r - 2'd1;
            default: count_s = count_r;
        endcase
    end

    // Storage plus registered valid/ready derived from next occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= '0;
            skid_r  <= '0;
            count_r <= 2'd0;
            valid_r <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            count_r <= count_s;
            valid_r <= (count_s != 2'd0);
            ready_r <= (count_s != 2'd2);
            if (pop_s || !valid_r) begin
                if (count_r == 2'd2) begin
                    head_r <= skid_r;
                end else if (push_s) begin
                    head_r <= in_data;
                end
            end
            if (push_s && valid_r && !pop_s) begin
                skid_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/stream_byte_swapper.sv
// Inline Avalon-ST byte swapper with packet-boundary mode switching, skid
// buffering and packet/byte/error counters on an Avalon-MM CSR port.
module stream_byte_swapper
    import stream_byte_swapper_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    parameter int EMPTY_W    = $clog2(DATA_BYTES)
) (
    input  logic                  clk,
    input  logic                  reset,
    stream_byte_swapper_if.slave  stream_in,
    stream_byte_swapper_if.master stream_out,
    input  logic [1:0]            csr_address,
    input  logic                  csr_read,
    input  logic                  csr_write,
    input  logic [31:0]           csr_writedata,
    output logic [31:0]           csr_readdata,
    output logic                  csr_readdatavalid,
    output logic                  csr_waitrequest
);

    localparam int DATA_BITS  = DATA_BYTES * 8;
    localparam int LOG2_BYTES = $clog2(DATA_BYTES);
    localparam int PAYLOAD_W  = DATA_BITS + EMPTY_W + 2;

    logic [MODE_W-1:0]    active_mode_r;
    logic [MODE_W-1:0]    pending_mode_r;
    logic                 in_packet_r;
    logic [31:0]          pkt_count_r;
    logic [31:0]          byte_count_r;
    logic [31:0]          err_count_r;
    logic [31:0]          csr_readdata_r;
    logic                 csr_readdatavalid_r;

    logic                 accept_s;
    logic                 sop_acc_s;
    logic                 eop_acc_s;
    logic                 stray_s;
    logic                 drop_s;
    logic                 fwd_s;
    logic                 err_s;
    logic                 wr_s;
    logic                 pending_flag_s;
    logic [31:0]          bytes_inc_s;
    logic [31:0]          rd_mux_s;
    logic [DATA_BITS-1:0] swapped_s;
    logic [PAYLOAD_W-1:0] payload_in_s;
    logic [PAYLOAD_W-1:0] payload_out_s;
    logic                 unused_wdata_s;

    assign accept_s  = stream_in.valid & stream_in.ready;
    assign sop_acc_s = accept_s & stream_in.startofpacket;
    assign eop_acc_s = accept_s & stream_in.endofpacket;
    // A continuation beat outside any packet is consumed but never buffered
    assign stray_s   = ~stream_in.startofpacket & ~in_packet_r;
    assign drop_s    = accept_s & stray_s;
    assign fwd_s     = accept_s & ~stray_s;
    assign err_s     = (sop_acc_s & in_packet_r) | drop_s;
    assign wr_s      = csr_write & ~csr_read;

    assign pending_flag_s = (pending_mode_r != active_mode_r);
    assign bytes_inc_s    = stream_in.endofpacket
                          ? (32'(DATA_BYTES) - 32'(stream_in.empty))
                          : 32'(DATA_BYTES);
    assign unused_wdata_s = ^csr_writedata[31:MODE_W];

    assign swapped_s    = DATA_BITS'(byteswap_group(MAX_BITS'(stream_in.data), LOG2_BYTES, active_mode_r));
    assign payload_in_s = {swapped_s, stream_in.empty, stream_in.startofpacket, stream_in.endofpacket};

    stream_skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   (payload_in_s),
        .in_valid  (stream_in.valid & ~stray_s),
        .in_ready  (stream_in.ready),
        .out_data  (payload_out_s),
        .out_valid (stream_out.valid),
        .out_ready (stream_out.ready)
    );

    assign stream_out.data          = payload_out_s[PAYLOAD_W-1 -: DATA_BITS];
    assign stream_out.empty         = payload_out_s[EMPTY_W+1:2];
    assign stream_out.startofpacket = payload_out_s[1];
    assign stream_out.endofpacket   = payload_out_s[0];

    assign csr_readdata      = csr_readdata_r;
    assign csr_readdatavalid = csr_readdatavalid_r;
    assign csr_waitrequest   = 1'b0;

    // CSR read mux over the pre-update register values
    always_comb begin
        rd_mux_s = 32'd0;
        case (csr_address)
            CSR_CTRL:  rd_mux_s = {23'd0, pending_flag_s, 5'd0, pending_mode_r};
            CSR_PKTS:  rd_mux_s = pkt_count_r;
            CSR_BYTES: rd_mux_s = byte_count_r;
            CSR_ERRS:  rd_mux_s = err_count_r;
            default:   rd_mux_s = 32'd0;
        endcase
    end

    // Mode, packet tracking and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            active_mode_r  <= '0;
            pending_mode_r <= '0;
            in_packet_r    <= 1'b0;
            pkt_count_r    <= 32'd0;
            byte_count_r   <= 32'd0;
            err_count_r    <= 32'd0;
        end else begin
            if (wr_s && (csr_address == CSR_CTRL)) begin
                pending_mode_r <= csr_writedata[MODE_W-1:0];
            end
            // Commit only between packets so a packet never mixes two modes
            if (!in_packet_r && !sop_acc_s) begin
                active_mode_r <= pending_mode_r;
            end
            if (eop_acc_s) begin
                in_packet_r <= 1'b0;
            end else if (sop_acc_s) begin
                in_packet_r <= 1'b1;
            end
            if (sop_acc_s) begin
                pkt_count_r <= pkt_count_r + 32'd1;
            end
            if (fwd_s) begin
                byte_count_r <= byte_count_r + bytes_inc_s;
            end
            if (wr_s && (csr_address == CSR_ERRS)) begin
                err_count_r <= 32'd0;
            end else if (err_s && (err_count_r != 32'hFFFF_FFFF)) begin
                err_count_r <= err_count_r + 32'd1;
            end
        end
    end

    // Fixed read latency of one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            csr_readdata_r      <= 32'd0;
            csr_readdatavalid_r <= 1'b0;
        end else begin
            csr_readdatavalid_r <= csr_read;
            if (csr_read) begin
                csr_readdata_r <= rd_mux_s;
            end
        end
    end

endmodule

// File: doc/stream_byte_swapper.md
Name: stream_byte_swapper

Overview:
Parametrised successor to the fixed 64-bit endian swapper. Sits inline on an Avalon-ST packet stream and reverses byte order within configurable group sizes, from 16-bit up to the full bus width. Adds a registered skid buffer for full-throughput backpressure and per-packet-boundary mode switching, so CSR accesses no longer stall on in-flight packets. Also adds byte and protocol-error counters on the Avalon-MM CSR port.

Parameters:
DATA_BYTES, 8, bus width in bytes; power of two, 2..64
EMPTY_W, $clog2(DATA_BYTES), width of empty field (derived; do not override)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
stream_in_data  in  DATA_BYTES*8  input beat, byte 0 at MSB (Avalon symbol order)
stream_in_empty  in  EMPTY_W  unused bytes on EOP beat
stream_in_valid / stream_in_startofpacket / stream_in_endofpacket  in  1 each  Avalon-ST qualifiers
stream_in_ready  out  1  registered; high when skid buffer has a free entry
stream_out_data / stream_out_empty  out  DATA_BYTES*8 / EMPTY_W  swapped beat, empty passed unchanged
stream_out_valid / stream_out_startofpacket / stream_out_endofpacket  out  1 each
stream_out_ready  in  1  readyLatency 0
csr_address  in  2  register select
csr_read / csr_write  in  1 each  Avalon-MM strobes
csr_writedata / csr_readdata  in / out  32 / 32  CSR data
csr_readdatavalid  out  1  fixed readLatency 1
csr_waitrequest  out  1  tied 0; no hold-off

Behaviour:
- Reset (sync, active-high): stream_in_ready=0 during reset, 1 on the first cycle after; stream_out_valid/sop/eop=0; stream_out_data/empty=0; csr_readdata=0; csr_readdatavalid=0; all counters=0; active_mode=pending_mode=0; in_packet=0. Reset mid-packet drops all buffered beats; no partial output.
- Transfer: a beat is accepted when valid&ready. An accepted beat appears on the output the next cycle if the output is empty or draining (latency 1). The 2-entry skid buffer sustains 1 beat/clk under a continuous stream_out_ready.
- stream_in_ready is a register; it deasserts only when both entries are full. Output holds data and qualifiers stable while valid&!ready.
- Swap: mode m = active_mode[2:0]. m=0 is passthrough. Otherwise bytes are reversed within each group of 2^m bytes. If m > log2(DATA_BYTES), the group saturates to the full bus. The swap is applied at the input, before the skid buffer. Empty bytes are swapped like any other byte; no realignment.
- CSR map:
  - addr 0 (R/W): [2:0] mode. A write loads pending_mode. [8] is RO pending flag, set while pending_mode != active_mode.
  - addr 1 (RO): packet count. +1 per accepted SOP beat; wraps 2^32-1 -> 0.
  - addr 2 (RO): byte count. Adds DATA_BYTES per accepted beat, or DATA_BYTES-empty on an EOP beat; 32-bit wrap.
  - addr 3: error count, saturates at 2^32-1; any write clears it to 0.
- Mode commit: active_mode<=pending_mode on any cycle where in_packet=0 and no SOP beat is accepted. If an SOP beat is accepted in the same cycle as a mode write, that packet uses the old mode and the commit waits for the packet's EOP. A single-beat packet (sop&eop) commits the next cycle.
- Errors (count +1 each):
  - SOP accepted while in_packet: the packet restarts and the beat is forwarded.
  - Non-SOP beat accepted while !in_packet: the beat is dropped (consumed, not forwarded, not byte-counted).
  - A simultaneous error and a write to addr 3 clears the count (write wins).
- in_packet: set on an accepted SOP without EOP; cleared on an accepted EOP.
- CSR read: csr_readdatavalid=1 exactly one cycle after csr_read. The read returns the counter value before any same-cycle update. Read and write in the same cycle: the read is serviced and the write is ignored.

Decomposition:
- Package stream_byte_swapper_pkg contains:
  - CSR address localparams (CSR_CTRL=0, CSR_PKTS=1, CSR_BYTES=2, CSR_ERRS=3)
  - mode width constant
  - function byteswap_group(data, m) built with generate-safe loops
- Sub-module stream_skid_buffer: 2-entry, parametrised payload width, carrying {data, empty, sop, eop}. Reused by other streaming blocks.

Test Plan:
- Mode 0, DATA_BYTES=8, 3-beat packet 0x0011223344556677 ... with empty=3 on EOP, ready=1 -> output identical at 1-cycle latency; pkts=1, bytes=21.
- Mode 1/2/3 single beat 0x0011223344556677 -> 0x1100332255447766 / 0x3322110077665544 / 0x7766554433221100. Mode 7 gives the same result as mode 3.
- Write mode=3 mid-packet -> rest of that packet unswapped; addr0 bit8=1 until EOP accepted, then 0. Next packet is fully reversed.
- stream_out_ready toggled 1010… with valid held high for 20 beats -> no beat lost or duplicated; stream_in_ready low only when 2 entries are full; output stable while stalled.
- SOP, SOP, EOP, then a stray beat with no SOP -> errs=2; stray beat not on output; write addr3 -> errs reads 0 next read.
- Assert reset for 1 cycle with 2 beats buffered -> outputs valid=0 the next cycle; all CSRs read 0; stream_in_ready=1 the following cycle.
